regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Configurable width, depth and write-to-read bypass.
- Adds a per-register pending-write scoreboard. Decode sets a register's bit when it issues a write to it; writeback clears the bit.
- Sits between decode (read/issue) and writeback. Exports per-operand busy flags and an aggregate hazard so the pipeline controller can stall.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, ≥2.
- AW, $clog2(NREG), register address width; derived, not overridden.
- BYPASS, 1, 1 = same-cycle writeback forwarded to read ports and clears busy on those ports; 0 = reads return stored array contents only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- rs1_data  out  XLEN  read data, port 1 (combinational).
- rs2_data  out  XLEN  read data, port 2 (combinational).
- rs1_busy  out  1  rs1 has an outstanding write (combinational).
- rs2_busy  out  1  rs2 has an outstanding write (combinational).
- hazard  out  1  rs1_busy OR rs2_busy.
- issue_en  in  1  mark issue_rd pending.
- issue_rd  in  AW  destination register being issued.
- wb_en  in  1  writeback strobe.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  clear all pending bits (pipeline squash).
- pending_cnt  out  AW+1  registered count of set pending bits.

Behaviour:
- Reset (rst_n low at a clk edge): all NREG registers cleared to 0, all pending bits cleared, pending_cnt = 0.
  - Reset overrides wb_en, issue_en and flush in the same cycle.
  - Combinational outputs follow: data = 0, busy = 0, hazard = 0.
- Write: on a clk edge with wb_en = 1, mem[wb_rd] <= wb_data. Ignored when ZERO_REG = 1 and wb_rd = 0.
- Read, per port p (combinational):
  - ZERO_REG = 1 and rsp = 0: data = 0, busy = 0.
  - Else if BYPASS = 1, wb_en = 1 and wb_rd = rsp: data = wb_data, busy = 0.
  - Else: data = mem[rsp], busy = pend[rsp].
- Scoreboard update at each clk edge, in priority order:
  - rst_n low: all pending bits clear.
  - flush = 1: all pending bits clear. A simultaneous issue is also discarded; the writeback data is still written.
  - Otherwise:
    - wb_en clears pend[wb_rd].
    - issue_en sets pend[issue_rd].
    - If issue_rd = wb_rd, both strobes high: the set wins (new producer in flight), the bit ends 1.
  - Issue or writeback to register 0 with ZERO_REG = 1 has no scoreboard effect.
- Redundant strobes:
  - Issue to an already-pending register: bit stays 1, no error.
  - Writeback to a non-pending register: data written, bit stays 0.
- pending_cnt:
  - Registered population count of the pending vector after the update.
  - Valid the cycle after the edge; range 0..NREG (or NREG−1 with ZERO_REG).
  - Computed from next-state bits, so it equals popcount(pend) at all times outside reset.
- No read latency. Write latency is one edge, hidden by bypass when BYPASS = 1.

Test Plan:
- Reset, then write x5 = 0xDEADBEEF, then read rs1 = 5 next cycle: rs1_data = 0xDEADBEEF, busy = 0. Assert rst_n low one edge: rs1_data = 0, pending_cnt = 0.
- Write x0 = 0x1234 plus issue_rd = 0: rs1 = 0 reads 0, rs1_busy = 0, pending_cnt stays 0.
- Issue rd = 7, then rs2 = 7 next cycle: rs2_busy = 1, hazard = 1, pending_cnt = 1. Writeback x7 = 0xA5A5A5A5 same cycle as read with BYPASS = 1: rs2_data = 0xA5A5A5A5, rs2_busy = 0. After the edge, pend[7] = 0, pending_cnt = 0.
- Same sequence with BYPASS = 0: during the wb cycle rs2_data = old value and rs2_busy = 1; next cycle data = 0xA5A5A5A5, busy = 0.
- Pending x9, then same-cycle wb_rd = 9 and issue_rd = 9: pend[9] = 1, pending_cnt = 1, mem[9] updated.
- Issue x1..x4 on consecutive cycles (pending_cnt = 4), then flush with simultaneous issue_rd = 6: pending_cnt = 0, all busy = 0. Also randomised issue/wb/flush against a reference model, checking pending_cnt = popcount every cycle.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Decode/writeback side of the scoreboarded register file: read ports, issue and
// writeback strobes, squash, and the busy/hazard/pending-count status.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            hazard;
   logic            issue_en;
   logic [AW-1:0]   issue_rd;
   logic            wb_en;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic [AW:0]     pending_cnt;

   modport master (
      output rs1, rs2, issue_en, issue_rd, wb_en, wb_rd, wb_data, flush,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, hazard, pending_cnt
   );

   modport slave (
      input  rs1, rs2, issue_en, issue_rd, wb_en, wb_rd, wb_data, flush,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, hazard, pending_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with a pending-write scoreboard.
// Two combinational read ports with optional writeback bypass; registered pending count.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_sb_if.slave bus
);
   localparam int AW  = $clog2(NREG);
   localparam bit ZR  = (ZERO_REG != 0);
   localparam bit BYP = (BYPASS != 0);

   logic [XLEN-1:0] mem [NREG];
   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;
   logic [AW:0]     cnt_q;
   logic            wb_ok;

   logic [AW-1:0]   ra [2];
   logic [XLEN-1:0] rdata [2];
   logic            rbusy [2];

   function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) c = c + {{AW{1'b0}}, v[i]};
      return c;
   endfunction

   assign wb_ok = bus.wb_en && !(ZR && (bus.wb_rd == '0));

   // Set beats clear when issue and writeback target the same register.
   always_comb begin
      pend_nxt = pend;
      if (bus.flush) begin
         pend_nxt = '0;
      end else begin
         if (bus.wb_en)    pend_nxt[bus.wb_rd]    = 1'b0;
         if (bus.issue_en) pend_nxt[bus.issue_rd] = 1'b1;
      end
      if (ZR) pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
         pend  <= '0;
         cnt_q <= '0;
      end else begin
         if (wb_ok) mem[bus.wb_rd] <= bus.wb_data;
         pend  <= pend_nxt;
         cnt_q <= popcount(pend_nxt);
      end
   end

   assign ra[0] = bus.rs1;
   assign ra[1] = bus.rs2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         rbusy[p] = 1'b0;
         if (ZR && (ra[p] == '0)) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
         end else if (BYP && bus.wb_en && (bus.wb_rd == ra[p])) begin
            rdata[p] = bus.wb_data;
            rbusy[p] = 1'b0;
         end else begin
            rdata[p] = mem[ra[p]];
            rbusy[p] = pend[ra[p]];
         end
      end
   end

   assign bus.rs1_data    = rdata[0];
   assign bus.rs2_data    = rdata[1];
   assign bus.rs1_busy    = rbusy[0];
   assign bus.rs2_busy    = rbusy[1];
   assign bus.hazard      = rbusy[0] | rbusy[1];
   assign bus.pending_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share one stimulus
// stream and are checked every cycle against an array-based model of the register file.
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [AW-1:0]   rs1, rs2, issue_rd, wb_rd;
   logic            issue_en, wb_en, flush;
   logic [XLEN-1:0] wb_data;

   regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_b ();
   regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_n ();

   assign bus_b.rs1 = rs1;           assign bus_n.rs1 = rs1;
   assign bus_b.rs2 = rs2;           assign bus_n.rs2 = rs2;
   assign bus_b.issue_en = issue_en; assign bus_n.issue_en = issue_en;
   assign bus_b.issue_rd = issue_rd; assign bus_n.issue_rd = issue_rd;
   assign bus_b.wb_en = wb_en;       assign bus_n.wb_en = wb_en;
   assign bus_b.wb_rd = wb_rd;       assign bus_n.wb_rd = wb_rd;
   assign bus_b.wb_data = wb_data;   assign bus_n.wb_data = wb_data;
   assign bus_b.flush = flush;       assign bus_n.flush = flush;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .ZERO_REG(1)) dut_n (
      .clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state as plain arrays.
   logic [XLEN-1:0] m_mem [NREG];
   bit   [NREG-1:0] m_pend;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) m_mem[i] = '0;
         m_pend = '0;
         chk_on = 1'b1;
      end else begin
         if (wb_en && wb_rd != 0) m_mem[wb_rd] = wb_data;
         if (flush) m_pend = '0;
         else begin
            if (wb_en && wb_rd != 0)       m_pend[wb_rd] = 1'b0;
            if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1'b1;
         end
      end
   end

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && wb_en && wb_rd == a) return wb_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && wb_en && wb_rd == a) return 1'b0;
      return m_pend[a];
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("b_rs1_data", bus_b.rs1_data, exp_data(rs1, 1'b1));
         chk("b_rs2_data", bus_b.rs2_data, exp_data(rs2, 1'b1));
         chk("b_rs1_busy", bus_b.rs1_busy, exp_busy(rs1, 1'b1));
         chk("b_rs2_busy", bus_b.rs2_busy, exp_busy(rs2, 1'b1));
         chk("b_hazard", bus_b.hazard, exp_busy(rs1, 1'b1) | exp_busy(rs2, 1'b1));
         chk("b_pending_cnt", bus_b.pending_cnt, $countones(m_pend));
         chk("n_rs1_data", bus_n.rs1_data, exp_data(rs1, 1'b0));
         chk("n_rs2_data", bus_n.rs2_data, exp_data(rs2, 1'b0));
         chk("n_rs1_busy", bus_n.rs1_busy, exp_busy(rs1, 1'b0));
         chk("n_rs2_busy", bus_n.rs2_busy, exp_busy(rs2, 1'b0));
         chk("n_hazard", bus_n.hazard, exp_busy(rs1, 1'b0) | exp_busy(rs2, 1'b0));
         chk("n_pending_cnt", bus_n.pending_cnt, $countones(m_pend));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_en = 1'b0;
      wb_en    = 1'b0;
      flush    = 1'b0;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, NREG - 1));
   endfunction

   initial begin
      rst_n = 1'b0; rs1 = '0; rs2 = '0; issue_rd = '0; wb_rd = '0; wb_data = '0;
      idle();
      step(); step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("lit_reset_cnt", bus_b.pending_cnt, 0);
      chk("lit_reset_data", bus_b.rs1_data, 0);

      // write x5, read back next cycle
      step();
      wb_en = 1'b1; wb_rd = 5; wb_data = 32'hDEADBEEF;
      step();
      idle(); rs1 = 5;
      @(negedge clk);
      chk("lit_x5_data", bus_n.rs1_data, 32'hDEADBEEF);
      chk("lit_x5_busy", bus_n.rs1_busy, 0);

      // one reset edge clears it
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("lit_rst_x5_data", bus_b.rs1_data, 0);
      chk("lit_rst_cnt", bus_b.pending_cnt, 0);

      // x0 ignores write and issue
      step();
      wb_en = 1'b1; wb_rd = 0; wb_data = 32'h1234; issue_en = 1'b1; issue_rd = 0; rs1 = 0;
      step();
      idle();
      @(negedge clk);
      chk("lit_x0_data", bus_b.rs1_data, 0);
      chk("lit_x0_busy", bus_b.rs1_busy, 0);
      chk("lit_x0_cnt", bus_b.pending_cnt, 0);

      // issue x7, then read/writeback race on x7
      step();
      issue_en = 1'b1; issue_rd = 7;
      step();
      idle(); rs2 = 7;
      @(negedge clk);
      chk("lit_x7_busy", bus_b.rs2_busy, 1);
      chk("lit_x7_hazard", bus_b.hazard, 1);
      chk("lit_x7_cnt", bus_b.pending_cnt, 1);
      step();
      wb_en = 1'b1; wb_rd = 7; wb_data = 32'hA5A5A5A5;
      @(negedge clk);
      chk("lit_byp_data", bus_b.rs2_data, 32'hA5A5A5A5);
      chk("lit_byp_busy", bus_b.rs2_busy, 0);
      chk("lit_nobyp_data", bus_n.rs2_data, 0);
      chk("lit_nobyp_busy", bus_n.rs2_busy, 1);
      step();
      idle();
      @(negedge clk);
      chk("lit_x7_cnt_after", bus_b.pending_cnt, 0);
      chk("lit_nobyp_data_after", bus_n.rs2_data, 32'hA5A5A5A5);
      chk("lit_nobyp_busy_after", bus_n.rs2_busy, 0);

      // same-cycle wb and issue to x9: set wins, data written
      step();
      issue_en = 1'b1; issue_rd = 9;
      step();
      wb_en = 1'b1; wb_rd = 9; wb_data = 32'h0000_0099;
      step();
      idle(); rs1 = 9;
      @(negedge clk);
      chk("lit_x9_busy", bus_b.rs1_busy, 1);
      chk("lit_x9_cnt", bus_b.pending_cnt, 1);
      chk("lit_x9_data", bus_n.rs1_data, 32'h99);

      // flush, issue x1..x4, then flush with a discarded issue of x6
      step();
      flush = 1'b1;
      step();
      idle();
      for (int r = 1; r <= 4; r++) begin
         issue_en = 1'b1; issue_rd = AW'(r);
         step();
      end
      idle();
      @(negedge clk);
      chk("lit_x1_4_cnt", bus_b.pending_cnt, 4);
      step();
      flush = 1'b1; issue_en = 1'b1; issue_rd = 6;
      step();
      idle(); rs1 = 6; rs2 = 1;
      @(negedge clk);
      chk("lit_flush_cnt", bus_b.pending_cnt, 0);
      chk("lit_flush_busy6", bus_b.rs1_busy, 0);
      chk("lit_flush_busy1", bus_b.rs2_busy, 0);

      // randomised traffic, checked every cycle by the compare process
      for (int c = 0; c < 3000; c++) begin
         step();
         rst_n    = ($urandom_range(0, 99) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         issue_en = $urandom_range(0, 1) == 1;
         issue_rd = pick_addr();
         wb_en    = $urandom_range(0, 1) == 1;
         wb_rd    = ($urandom_range(0, 3) == 0) ? issue_rd : pick_addr();
         wb_data  = $urandom;
         rs1      = ($urandom_range(0, 2) == 0) ? wb_rd : pick_addr();
         rs2      = ($urandom_range(0, 2) == 0) ? issue_rd : pick_addr();
      end
      step();
      idle(); rst_n = 1'b1;
      step();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
